virtual_point_projector: RTL and testbench



---
 rtl/projector_pkg.sv | 27 ++
 rtl/point_affine_mac.sv | 45 ++++
 rtl/virtual_point_projector.sv | 188 ++++++++++++++++++
 tb/tb_virtual_point_projector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/projector_pkg.sv
// Shared widths, defaults and types for the virtual point projector.
package projector_pkg;

    localparam int unsigned DEF_H_ACTIVE  = 1280;
    localparam int unsigned DEF_V_ACTIVE  = 720;
    localparam int unsigned X_W           = 11;
    localparam int unsigned Y_W           = 10;
    localparam int unsigned SCALAR_W      = 16;
    localparam int unsigned DEF_FRAC_BITS = 8;
    localparam int unsigned PROD_W        = 28;
    localparam int unsigned ACC_W         = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_REQ,
        S_WAIT,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_FINAL,
        S_OUT
    } state_t;

    typedef logic signed [SCALAR_W-1:0] scalar_t;

endpackage

// File: rtl/point_affine_mac.sv
// One-axis signed multiply-accumulate: acc += scalar[sel] * delta[sel].
module point_affine_mac
    import projector_pkg::*;
#(
    parameter int unsigned DELTA_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       acc_en,
    input  logic [1:0]                 sel,
    input  logic [2:0][SCALAR_W-1:0]   scalars,
    input  logic [2:0][DELTA_W-1:0]    deltas,
    output logic signed [ACC_W-1:0]    acc
);

    scalar_t                    s_c;
    logic signed [DELTA_W-1:0]  d_c;
    logic signed [PROD_W-1:0]   prod_c;

    // Select the operand pair for this cycle and form the full-precision product.
    always_comb begin
        s_c = '0;
        d_c = '0;
        case (sel)
            2'd0: begin s_c = scalar_t'(scalars[0]); d_c = $signed(deltas[0]); end
            2'd1: begin s_c = scalar_t'(scalars[1]); d_c = $signed(deltas[1]); end
            2'd2: begin s_c = scalar_t'(scalars[2]); d_c = $signed(deltas[2]); end
            default: ;
        endcase
        prod_c = PROD_W'(s_c) * PROD_W'(d_c);
    end

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/virtual_point_projector.sv
// Projects per-frame virtual points through four tracked markers to clipped screen pixels.
module virtual_point_projector
    import projector_pkg::*;
#(
    parameter int unsigned N_VIRTUAL_POINTS = 48,
    parameter int unsigned LOAD_LATENCY     = 2,
    parameter int unsigned FRAC_BITS        = DEF_FRAC_BITS,
    parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        frame_start_in,
    input  logic [3:0][X_W-1:0]         tracking_x_in,
    input  logic [3:0][Y_W-1:0]         tracking_y_in,
    input  logic [2:0][SCALAR_W-1:0]    point_scalars_in,
    input  logic [3:0]                  point_color_in,
    output logic                        next_point_out,
    output logic [X_W-1:0]              pixel_x_out,
    output logic [Y_W-1:0]              pixel_y_out,
    output logic [3:0]                  color_out,
    output logic                        on_screen_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        busy_out,
    output logic                        done_out
);

    localparam int unsigned DX_W   = X_W + 1;
    localparam int unsigned DY_W   = Y_W + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned IDX_W  = (N_VIRTUAL_POINTS > 1) ? $clog2(N_VIRTUAL_POINTS) : 1;
    localparam int unsigned WAIT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q;
    logic [WAIT_W-1:0]          wait_q;
    logic [X_W-1:0]             t0x_q;
    logic [Y_W-1:0]             t0y_q;
    logic [2:0][DX_W-1:0]       dx_q;
    logic [2:0][DY_W-1:0]       dy_q;
    logic [2:0][SCALAR_W-1:0]   scal_q;
    logic [3:0]                 color_q;
    logic signed [ACC_W-1:0]    acc_x, acc_y;

    logic                       mac_clear_c, mac_en_c;
    logic [1:0]                 mac_sel_c;
    logic                       last_idx_c, wait_last_c, hs_c;
    logic signed [SUM_W-1:0]    sum_x_c, sum_y_c;
    logic [X_W-1:0]             clip_x_c;
    logic [Y_W-1:0]             clip_y_c;
    logic                       on_c;

    assign last_idx_c  = (idx_q == IDX_W'(N_VIRTUAL_POINTS - 1));
    assign wait_last_c = (wait_q == WAIT_W'(LOAD_LATENCY - 1));
    assign hs_c        = (state_q == S_OUT) && ready_in;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and MAC sequencing.
    always_comb begin
        state_d     = state_q;
        mac_clear_c = 1'b0;
        mac_en_c    = 1'b0;
        mac_sel_c   = 2'd0;
        case (state_q)
            S_IDLE:  if (frame_start_in) state_d = S_LATCH;
            S_LATCH: state_d = S_REQ;
            S_REQ: begin
                mac_clear_c = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT:  if (wait_last_c) state_d = S_MAC0;
            S_MAC0: begin mac_en_c = 1'b1; mac_sel_c = 2'd0; state_d = S_MAC1; end
            S_MAC1: begin mac_en_c = 1'b1; mac_sel_c = 2'd1; state_d = S_MAC2; end
            S_MAC2: begin mac_en_c = 1'b1; mac_sel_c = 2'd2; state_d = S_FINAL; end
            S_FINAL: state_d = S_OUT;
            S_OUT:   if (ready_in) state_d = last_idx_c ? S_IDLE : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Add T0, floor-shift the accumulated offset, and clip to the visible area.
    always_comb begin
        sum_x_c = SUM_W'($signed({1'b0, t0x_q})) + SUM_W'(acc_x >>> FRAC_BITS);
        sum_y_c = SUM_W'($signed({1'b0, t0y_q})) + SUM_W'(acc_y >>> FRAC_BITS);
        on_c    = 1'b1;
        if (sum_x_c[SUM_W-1]) begin
            clip_x_c = '0;
            on_c     = 1'b0;
        end else if (sum_x_c >= $signed(SUM_W'(H_ACTIVE))) begin
            clip_x_c = X_W'(H_ACTIVE - 1);
            on_c     = 1'b0;
        end else begin
            clip_x_c = X_W'(sum_x_c);
        end
        if (sum_y_c[SUM_W-1]) begin
            clip_y_c = '0;
            on_c     = 1'b0;
        end else if (sum_y_c >= $signed(SUM_W'(V_ACTIVE))) begin
            clip_y_c = Y_W'(V_ACTIVE - 1);
            on_c     = 1'b0;
        end else begin
            clip_y_c = Y_W'(sum_y_c);
        end
    end

    // Datapath registers and registered stream/handshake outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_q          <= '0;
            wait_q         <= '0;
            t0x_q          <= '0;
            t0y_q          <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            scal_q         <= '0;
            color_q        <= '0;
            next_point_out <= 1'b0;
            pixel_x_out    <= '0;
            pixel_y_out    <= '0;
            color_out      <= '0;
            on_screen_out  <= 1'b0;
            valid_out      <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            next_point_out <= (state_d == S_REQ);
            valid_out      <= (state_d == S_OUT);
            busy_out       <= (state_d != S_IDLE);
            done_out       <= hs_c && last_idx_c;
            case (state_q)
                S_LATCH: begin
                    t0x_q <= tracking_x_in[0];
                    t0y_q <= tracking_y_in[0];
                    for (int k = 0; k < 3; k++) begin
                        dx_q[k] <= DX_W'($signed({1'b0, tracking_x_in[k+1]}) - $signed({1'b0, tracking_x_in[0]}));
                        dy_q[k] <= DY_W'($signed({1'b0, tracking_y_in[k+1]}) - $signed({1'b0, tracking_y_in[0]}));
                    end
                    idx_q <= '0;
                end
                S_REQ: wait_q <= '0;
                S_WAIT: begin
                    wait_q <= wait_q + WAIT_W'(1);
                    if (wait_last_c) begin
                        scal_q  <= point_scalars_in;
                        color_q <= point_color_in;
                    end
                end
                S_FINAL: begin
                    pixel_x_out   <= clip_x_c;
                    pixel_y_out   <= clip_y_c;
                    color_out     <= color_q;
                    on_screen_out <= on_c;
                end
                S_OUT: if (ready_in && !last_idx_c) idx_q <= idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    point_affine_mac #(.DELTA_W(DX_W)) u_mac_x (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .clear   (mac_clear_c),
        .acc_en  (mac_en_c),
        .sel     (mac_sel_c),
        .scalars (scal_q),
        .deltas  (dx_q),
        .acc     (acc_x)
    );

    point_affine_mac #(.DELTA_W(DY_W)) u_mac_y (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .clear   (mac_clear_c),
        .acc_en  (mac_en_c),
        .sel     (mac_sel_c),
        .scalars (scal_q),
        .deltas  (dy_q),
        .acc     (acc_y)
    );

endmodule

// File: tb/tb_virtual_point_projector.sv
// Directed bench for virtual_point_projector with a small load_animation stand-in.
module tb_virtual_point_projector;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              frame_start_in;
    logic [3:0][10:0]  tracking_x_in;
    logic [3:0][9:0]   tracking_y_in;
    logic [2:0][15:0]  point_scalars_in;
    logic [3:0]        point_color_in;
    logic              next_point_out;
    logic [10:0]       pixel_x_out;
    logic [9:0]        pixel_y_out;
    logic [3:0]        color_out;
    logic              on_screen_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy_out;
    logic              done_out;

    virtual_point_projector #(
        .N_VIRTUAL_POINTS (N),
        .LOAD_LATENCY     (LAT)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .tracking_x_in    (tracking_x_in),
        .tracking_y_in    (tracking_y_in),
        .point_scalars_in (point_scalars_in),
        .point_color_in   (point_color_in),
        .next_point_out   (next_point_out),
        .pixel_x_out      (pixel_x_out),
        .pixel_y_out      (pixel_y_out),
        .color_out        (color_out),
        .on_screen_out    (on_screen_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          up_idx = 0;
    logic [15:0] tbl_s [4][3];
    logic [3:0]  tbl_c [4];

    int          np_q[$];
    int          vr_q[$];
    int          hs_q[$];
    int          done_q[$];
    logic [25:0] beat_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_beat(input int i, input int ex, input int ey, input int ec, input int eon);
        logic [25:0] b;
        if (i >= beat_q.size()) begin
            check($sformatf("beat%0d_present", i), 0, 1);
            return;
        end
        b = beat_q[i];
        check($sformatf("beat%0d_x", i),  32'(b[25:15]), ex);
        check($sformatf("beat%0d_y", i),  32'(b[14:5]),  ey);
        check($sformatf("beat%0d_c", i),  32'(b[4:1]),   ec);
        check($sformatf("beat%0d_on", i), 32'(b[0]),     eon);
    endtask

    task automatic set_track(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2, input int x3, input int y3);
        tracking_x_in = {11'(x3), 11'(x2), 11'(x1), 11'(x0)};
        tracking_y_in = {10'(y3), 10'(y2), 10'(y1), 10'(y0)};
    endtask

    task automatic set_pt(input int i, input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [3:0] c);
        tbl_s[i][0] = s0;
        tbl_s[i][1] = s1;
        tbl_s[i][2] = s2;
        tbl_c[i]    = c;
    endtask

    task automatic clear_log();
        np_q.delete();
        vr_q.delete();
        hs_q.delete();
        done_q.delete();
        beat_q.delete();
        up_idx = 0;
    endtask

    task automatic pulse_start();
        frame_start_in = 1'b1;
        @(posedge clk_in); #1;
        frame_start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("done_seen", 32'(done_q.size() > 0), 1);
    endtask

    task automatic load_frame_a();
        set_track(100, 100, 200, 100, 100, 200, 100, 100);
        set_pt(0, 16'h0080, 16'h0100, 16'h0000, 4'd5);
        set_pt(1, 16'hFF80, 16'h0000, 16'h0000, 4'd6);
        set_pt(2, 16'hFFFF, 16'h0000, 16'h0000, 4'd7);
        set_pt(3, 16'h0000, 16'h0800, 16'h7FFF, 4'd8);
    endtask

    // Cycle counter, advanced on the active edge.
    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Monitor: log requests, valid rises, handshakes and done pulses mid-cycle.
    initial begin
        logic valid_d;
        valid_d = 1'b0;
        forever begin
            @(negedge clk_in);
            if (next_point_out) np_q.push_back(cyc);
            if (valid_out && !valid_d) vr_q.push_back(cyc);
            if (valid_out && ready_in) begin
                beat_q.push_back({pixel_x_out, pixel_y_out, color_out, on_screen_out});
                hs_q.push_back(cyc);
            end
            if (done_out) done_q.push_back(cyc);
            valid_d = valid_out;
        end
    end

    // Upstream stand-in: junk until LAT cycles after the request, then the table entry.
    initial begin
        point_scalars_in = '0;
        point_color_in   = '0;
        forever begin
            @(negedge clk_in);
            if (next_point_out) begin
                point_scalars_in = {16'($urandom), 16'($urandom), 16'($urandom)};
                point_color_in   = 4'($urandom);
                repeat (LAT) @(posedge clk_in);
                #1;
                point_scalars_in = {tbl_s[up_idx % 4][2], tbl_s[up_idx % 4][1], tbl_s[up_idx % 4][0]};
                point_color_in   = tbl_c[up_idx % 4];
                up_idx++;
            end
        end
    end

    initial begin
        int n;
        rst_in         = 1'b0;
        frame_start_in = 1'b0;
        ready_in       = 1'b1;
        set_track(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", 32'(valid_out), 0);
        check("rst_np",    32'(next_point_out), 0);
        check("rst_busy",  32'(busy_out), 0);
        check("rst_done",  32'(done_out), 0);
        check("rst_x",     32'(pixel_x_out), 0);
        check("rst_y",     32'(pixel_y_out), 0);
        check("rst_on",    32'(on_screen_out), 0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Frame A: nominal projection, floor shift, y clip, stream timing.
        load_frame_a();
        clear_log();
        pulse_start();
        wait_done(200);
        check("a_np_count",   32'(np_q.size()), 4);
        check("a_beat_count", 32'(hs_q.size()), 4);
        check("a_latency",    32'(vr_q[0] - np_q[0]), 7);
        check("a_np_period",  32'(np_q[1] - np_q[0]), 8);
        check("a_done_cyc",   32'(done_q[0] - hs_q[3]), 1);
        check("a_done_count", 32'(done_q.size()), 1);
        check("a_busy_end",   32'(busy_out), 0);
        check_beat(0, 150, 200, 5, 1);
        check_beat(1,  50, 100, 6, 1);
        check_beat(2,  99, 100, 7, 1);
        check_beat(3, 100, 719, 8, 0);

        // Frame B: x clipping, back-pressure stall, ignored mid-batch frame_start.
        set_track(50, 50, 150, 50, 50, 50, 50, 50);
        set_pt(0, 16'hFF00, 16'h0000, 16'h0000, 4'd1);
        set_pt(1, 16'h7F00, 16'h0000, 16'h0000, 4'd2);
        set_pt(2, 16'h0100, 16'h0000, 16'h0000, 4'd3);
        set_pt(3, 16'h0000, 16'h0000, 16'h0000, 4'd4);
        clear_log();
        ready_in = 1'b0;
        pulse_start();
        n = 0;
        while (!valid_out && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("b_valid_seen", 32'(valid_out), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            check($sformatf("b_stall%0d_valid", i), 32'(valid_out), 1);
            check($sformatf("b_stall%0d_x", i),     32'(pixel_x_out), 0);
            check($sformatf("b_stall%0d_y", i),     32'(pixel_y_out), 50);
            check($sformatf("b_stall%0d_np", i),    32'(np_q.size()), 1);
        end
        ready_in = 1'b1;
        n = 0;
        while (np_q.size() < 3 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        set_track(500, 500, 500, 500, 500, 500, 500, 500);
        pulse_start();
        wait_done(200);
        check("b_resume_np",  32'(np_q[1] - hs_q[0]), 1);
        check("b_np_count",   32'(np_q.size()), 4);
        check("b_beat_count", 32'(hs_q.size()), 4);
        check("b_done_count", 32'(done_q.size()), 1);
        check_beat(0,    0, 50, 1, 0);
        check_beat(1, 1279, 50, 2, 0);
        check_beat(2,  150, 50, 3, 1);
        check_beat(3,   50, 50, 4, 1);
        repeat (10) @(posedge clk_in);
        #1;
        check("b_idle_busy", 32'(busy_out), 0);
        check("b_idle_np",   32'(np_q.size()), 4);

        // Frame C: reset asserted during MAC1, then a clean restart.
        load_frame_a();
        clear_log();
        pulse_start();
        n = 0;
        @(negedge clk_in);
        while (!next_point_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("c_req_seen", 32'(next_point_out), 1);
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("c_rst_busy",  32'(busy_out), 0);
        check("c_rst_valid", 32'(valid_out), 0);
        check("c_rst_x",     32'(pixel_x_out), 0);
        check("c_rst_y",     32'(pixel_y_out), 0);
        check("c_rst_color", 32'(color_out), 0);
        check("c_rst_on",    32'(on_screen_out), 0);
        repeat (2) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        clear_log();
        repeat (20) @(posedge clk_in);
        #1;
        check("c_no_req", 32'(np_q.size()), 0);
        pulse_start();
        wait_done(200);
        check("c_np_count", 32'(np_q.size()), 4);
        check_beat(0, 150, 200, 5, 1);
        check_beat(3, 100, 719, 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
